// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and pixel format.
// The framebuffer word address width is also used by the MMIO decode.
package vga_pkg;

    localparam int DEF_FB_W   = 400;
    localparam int DEF_FB_H   = 300;
    localparam int DEF_H_FP   = 40;
    localparam int DEF_H_SYNC = 128;
    localparam int DEF_H_BP   = 88;
    localparam int DEF_V_FP   = 1;
    localparam int DEF_V_SYNC = 4;
    localparam int DEF_V_BP   = 23;
    localparam int FB_ADDR_W  = 17;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic pixel_t unpack_pixel(input logic [23:0] w);
        return pixel_t'(w);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, sync windows, active area and frame/line markers.
// Counters only move on pixel ticks.
module vga_timing
    import vga_pkg::*;
#(
    parameter int ACT_W  = DEF_FB_W,
    parameter int ACT_H  = DEF_FB_H,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int HCW    = 10,
    parameter int VCW    = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    output logic [HCW-1:0] hcnt,
    output logic [VCW-1:0] vcnt,
    output logic           active,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           line_end,
    output logic           frame_end,
    output logic           frame_tick
);

    localparam int H_TOT = ACT_W + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = ACT_H + V_FP + V_SYNC + V_BP;

    localparam logic [HCW-1:0] H_ACT  = HCW'(ACT_W);
    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOT - 1);
    localparam logic [HCW-1:0] HS_BEG = HCW'(ACT_W + H_FP);
    localparam logic [HCW-1:0] HS_END = HCW'(ACT_W + H_FP + H_SYNC - 1);
    localparam logic [VCW-1:0] V_ACT  = VCW'(ACT_H);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOT - 1);
    localparam logic [VCW-1:0] VS_BEG = VCW'(ACT_H + V_FP);
    localparam logic [VCW-1:0] VS_END = VCW'(ACT_H + V_FP + V_SYNC - 1);

    // advance the raster position by one pixel per tick
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // decode windows and boundary markers from the current position
    always_comb begin
        active     = (hcnt < H_ACT) && (vcnt < V_ACT);
        hsync_n    = !((hcnt >= HS_BEG) && (hcnt <= HS_END));
        vsync_n    = !((vcnt >= VS_BEG) && (vcnt <= VS_END));
        line_end   = pix_en && (hcnt == H_LAST);
        frame_end  = line_end && (vcnt == V_LAST);
        frame_tick = pix_en && !rst && (hcnt == '0) && (vcnt == '0);
    end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: addressing, sync handshake, 2-clock output pipeline.
// Define VGA_SCANOUT_PIXDOUBLE_EN for 2x pixel/line doubling (800x600).
module vga_scanout
    import vga_pkg::*;
#(
    parameter int FB_W   = DEF_FB_W,
    parameter int FB_H   = DEF_FB_H,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              sync_req,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [31:0]       fb_rd_data,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start,
    output logic              live
);

`ifdef VGA_SCANOUT_PIXDOUBLE_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif

    localparam int ACT_W = FB_W * SCALE;
    localparam int ACT_H = FB_H * SCALE;
    localparam int H_TOT = ACT_W + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = ACT_H + V_FP + V_SYNC + V_BP;
    localparam int HCW   = $clog2(H_TOT);
    localparam int VCW   = $clog2(V_TOT);

    localparam logic [VCW-1:0] V_ACT = VCW'(ACT_H);

    logic [HCW-1:0]    hcnt;
    logic [VCW-1:0]    vcnt;
    logic              active;
    logic              hsync_n;
    logic              vsync_n;
    logic              line_end;
    logic              frame_end;
    logic              frame_tick;
    logic [HCW-1:0]    col;
    logic              row_step;
    logic [ADDR_W-1:0] row_base;
    logic              pend;
    logic              live_eff;
    logic              p1;
    logic              d1_de;
    logic              d1_hs;
    logic              d1_vs;
    logic              d1_show;
    pixel_t            px;
    logic              unused_hi;

    vga_timing #(
        .ACT_W  (ACT_W),
        .ACT_H  (ACT_H),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .HCW    (HCW),
        .VCW    (VCW)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .active     (active),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .frame_tick (frame_tick)
    );

    // map raster position to framebuffer column and row advance
    always_comb begin
`ifdef VGA_SCANOUT_PIXDOUBLE_EN
        col      = hcnt >> 1;
        row_step = line_end && (vcnt < V_ACT) && vcnt[0];
`else
        col      = hcnt;
        row_step = line_end && (vcnt < V_ACT);
`endif
    end

    // a sync landing on the frame tick itself applies to that frame
    always_comb begin
        live_eff    = live || (frame_tick && (pend || sync_req));
        fb_rd_en    = pix_en && active && live_eff && !rst;
        fb_rd_addr  = row_base + ADDR_W'(col);
        frame_start = frame_tick;
        px          = unpack_pixel(fb_rd_data[23:0]);
        unused_hi   = ^fb_rd_data[31:24];
    end

    // row base restarts at the frame wrap, steps one fb row per row
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (frame_end) begin
            row_base <= '0;
        end else if (row_step) begin
            row_base <= row_base + ADDR_W'(FB_W);
        end
    end

    // latch sync requests and apply them only at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            live <= 1'b0;
        end else if (frame_tick) begin
            pend <= 1'b0;
            if (pend || sync_req) begin
                live <= 1'b1;
            end
        end else if (sync_req) begin
            pend <= 1'b1;
        end
    end

    // stage D1: capture timing alongside the framebuffer read
    always_ff @(posedge clk) begin
        if (rst) begin
            p1      <= 1'b0;
            d1_de   <= 1'b0;
            d1_hs   <= 1'b1;
            d1_vs   <= 1'b1;
            d1_show <= 1'b0;
        end else begin
            p1 <= pix_en;
            if (pix_en) begin
                d1_de   <= active;
                d1_hs   <= hsync_n;
                d1_vs   <= vsync_n;
                d1_show <= active && live_eff;
            end
        end
    end

    // output registers load once read data for the tick has arrived
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_de    <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else if (p1) begin
            vga_hsync <= d1_hs;
            vga_vsync <= d1_vs;
            vga_de    <= d1_de;
            vga_r     <= d1_show ? px.r : 8'h00;
            vga_g     <= d1_show ? px.g : 8'h00;
            vga_b     <= d1_show ? px.b : 8'h00;
        end
    end

endmodule
